// File: rtl/scrypt_romix_ctl.sv
// scrypt ROMix sequencing controller.
// Paces the salsa core, X registers and scratchpad through both ROMix phases.
module scrypt_romix_ctl #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 9,
    parameter int PASSES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] xaddr,
    output logic              busy,
    output logic              done,
    output logic              phase,
    output logic              feedback,
    output logic              half,
    output logic              x_we,
    output logic              v_xor,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [ADDR_W-1:0] iter
);

    localparam int CYC_SALSA = LAT * PASSES;
    localparam int CYC_BM    = 2 * CYC_SALSA;
    localparam int CW        = $clog2(CYC_BM);

    localparam logic [CW-1:0] C_S   = CW'(CYC_SALSA);
    localparam logic [CW-1:0] C_SM1 = CW'(CYC_SALSA - 1);
    localparam logic [CW-1:0] C_BM1 = CW'(CYC_BM - 1);
    localparam logic [CW-1:0] C_BM2 = CW'(CYC_BM - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] P1   = 2'd1;
    localparam logic [1:0] P2   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cyc;
    logic          run;
    logic          wrap;
    logic          last;

    assign run  = (state == P1) || (state == P2);
    assign wrap = run && (cyc == C_BM1);
    assign last = (iter == {ADDR_W{1'b1}});

    // Phase sequencing plus the cycle/iteration counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cyc   <= '0;
            iter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= P1;
                        cyc   <= '0;
                        iter  <= '0;
                    end
                end
                P1, P2: begin
                    if (cyc == C_BM1) begin
                        cyc  <= '0;
                        iter <= iter + 1'b1;
                        if (last) begin
                            state <= (state == P1) ? P2 : DONE;
                            iter  <= '0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture j one cycle ahead, since the core presents Xaddr early.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rd_addr <= '0;
        end else if (run && (cyc == C_BM2)) begin
            ram_rd_addr <= xaddr;
        end
    end

    assign busy        = run;
    assign done        = (state == DONE);
    assign phase       = (state == P2);
    assign feedback    = run && (cyc != '0) && (cyc != C_S);
    assign half        = run && (cyc >= C_S);
    assign x_we        = run && ((cyc == C_SM1) || (cyc == C_BM1));
    assign v_xor       = (state == P2) && (cyc == '0);
    assign ram_we      = (state == P1) && (cyc == '0);
    assign ram_wr_addr = iter;
    assign ram_rd_en   = wrap && ((state == P1) ? last : !last);

endmodule

// File: tb/tb_scrypt_romix_ctl.sv
// Randomized scoreboard bench for scrypt_romix_ctl.
// Expected events are queued at start issue; a monitor checks every cycle.
module tb_scrypt_romix_ctl;

    localparam int AW = 2;
    localparam int N  = 1 << AW;
    localparam int BM = 72;
    localparam int HC = N * BM;

    logic          clk = 0;
    logic          reset = 1;
    logic          start = 0;
    logic [AW-1:0] xaddr = '0;
    logic          busy, done, phase, feedback, half, x_we, v_xor;
    logic          ram_we, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr, iter;

    scrypt_romix_ctl #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .xaddr(xaddr),
        .busy(busy), .done(done), .phase(phase), .feedback(feedback),
        .half(half), .x_we(x_we), .v_xor(v_xor), .ram_we(ram_we),
        .ram_wr_addr(ram_wr_addr), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .iter(iter)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int addr; } ev_t;
    ev_t we_q[$];
    int  rd_q[$];
    int  done_q[$];

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    bit mon_en = 0;
    bit m_valid = 0;
    int m_t0 = 0;
    int exp_rd = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0d want=%0d", n, cyc_cnt, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        xaddr = AW'($urandom);
    endtask

    function automatic bit model_busy();
        int t;
        t = cyc_cnt - m_t0 - 1;
        return m_valid && t >= 0 && t <= 2 * HC;
    endfunction

    task automatic issue_start();
        int c;
        start = 1;
        if (!model_busy()) begin
            c = cyc_cnt;
            m_valid = 1;
            m_t0 = c;
            for (int i = 0; i < N; i++) we_q.push_back('{c + 1 + i * BM, i});
            rd_q.push_back(c + 1 + (N - 1) * BM + BM - 1);
            for (int i = 0; i < N - 1; i++) rd_q.push_back(c + 1 + HC + i * BM + BM - 1);
            done_q.push_back(c + 1 + 2 * HC);
        end
    endtask

    // Monitor: per-cycle expectations from elapsed time, plus event scoreboard.
    always @(negedge clk) begin
        int  t, w, it;
        bit  inh, dn, p;
        ev_t e;
        int  d;
        if (mon_en) begin
            t = cyc_cnt - m_t0 - 1;
            inh = m_valid && t >= 0 && t < 2 * HC;
            dn = m_valid && t == 2 * HC;
            if (inh) begin
                p = t >= HC;
                w = t % BM;
                it = (t % HC) / BM;
                chk("busy", busy, 1);
                chk("done", done, 0);
                chk("phase", phase, p);
                chk("iter", iter, it);
                chk("feedback", feedback, !(w == 0 || w == 36));
                chk("half", half, w >= 36);
                chk("x_we", x_we, w == 35 || w == 71);
                chk("v_xor", v_xor, p && w == 0);
                chk("ram_we", ram_we, !p && w == 0);
                chk("ram_rd_en", ram_rd_en, w == 71 && (p ? it != N - 1 : it == N - 1));
            end else if (dn) begin
                chk("done", done, 1);
                chk("busy", busy, 0);
                chk("ram_we", ram_we, 0);
                chk("ram_rd_en", ram_rd_en, 0);
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_phase", phase, 0);
                chk("idle_iter", iter, 0);
                chk("idle_fb", feedback, 0);
                chk("idle_half", half, 0);
                chk("idle_xwe", x_we, 0);
                chk("idle_vxor", v_xor, 0);
                chk("idle_we", ram_we, 0);
                chk("idle_rden", ram_rd_en, 0);
            end
            chk("ram_rd_addr", ram_rd_addr, exp_rd);
            if (inh && w == 70) exp_rd = xaddr;
            if (ram_we) begin
                if (we_q.size() == 0) chk("we_spurious", 1, 0);
                else begin
                    e = we_q.pop_front();
                    chk("we_cycle", cyc_cnt, e.cyc);
                    chk("we_addr", ram_wr_addr, e.addr);
                end
            end
            if (ram_rd_en) begin
                if (rd_q.size() == 0) chk("rd_spurious", 1, 0);
                else begin
                    d = rd_q.pop_front();
                    chk("rd_cycle", cyc_cnt, d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_spurious", 1, 0);
                else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc_cnt, d);
                end
            end
        end
    end

    task automatic wait_until(int c);
        while (cyc_cnt < c) tick();
    endtask

    initial begin
        reset = 1;
        tick();
        tick();
        mon_en = 1;
        chk("rst_wr_addr", ram_wr_addr, 0);
        chk("rst_rd_addr", ram_rd_addr, 0);
        chk("rst_iter", iter, 0);
        tick();
        reset = 0;
        tick();
        tick();

        // Hash 1: start re-pulsed during P1 and P2 must be ignored.
        issue_start();
        tick();
        start = 0;
        repeat ($urandom_range(5, 200)) tick();
        issue_start();
        tick();
        start = 0;
        wait_until(m_t0 + 1 + HC + $urandom_range(3, 200));
        issue_start();
        tick();
        start = 0;
        wait_until(m_t0 + 1 + 2 * HC + 3);
        chk("q_we_empty1", we_q.size(), 0);
        chk("q_rd_empty1", rd_q.size(), 0);
        chk("q_done_empty1", done_q.size(), 0);

        // Hash 2: abort with reset at P2 iteration 1, cycle 10.
        issue_start();
        tick();
        start = 0;
        wait_until(m_t0 + 1 + HC + BM + 10);
        reset = 1;
        @(posedge clk);
        m_valid = 0;
        we_q.delete();
        rd_q.delete();
        done_q.delete();
        exp_rd = 0;
        #1;
        reset = 0;
        repeat (4) tick();

        // Hash 3: full run after abort, start held in DONE is ignored.
        issue_start();
        tick();
        start = 0;
        wait_until(m_t0 + 1 + 2 * HC);
        issue_start();
        tick();
        start = 0;
        repeat (6) tick();
        chk("q_we_empty3", we_q.size(), 0);
        chk("q_rd_empty3", rd_q.size(), 0);
        chk("q_done_empty3", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
